// File: rtl/alu_sequencer.sv
// alu_sequencer: chains 8-bit ALU passes into ADC/SBC and 16-bit ops.
// Carry/borrow is folded in by an extra INC/DEC pass since the ALU has no carry-in.
module alu_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  seq_op,
    input  logic [4:0]  alu_op_in,
    input  logic [15:0] opnd_a,
    input  logic [15:0] opnd_b,
    input  logic        carry_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic [7:0]  flags,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [4:0]  alu_opcode,
    input  logic [7:0]  alu_out,
    input  logic [7:0]  alu_flags
);
    typedef enum logic [2:0] {IDLE, LO, HI, FIX, DONE} state_t;
    localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, INC = 5'd12, DEC = 5'd13;
    state_t state, state_next;
    logic [2:0] op;
    logic [4:0] aop;
    logic [15:0] a, b;
    logic cin;
    logic [7:0] lo, lo_f, hi, hi_f;
    logic accept, is16, neg, fixc;
    logic [7:0] pf, flg_n;
    logic [15:0] res_n;
    assign busy = state == LO || state == HI || state == FIX;
    assign done = state == DONE;
    assign accept = start && (state == IDLE || state == DONE);
    assign is16 = op == 3'd3 || op == 3'd4;
    assign neg = op == 3'd2 || op == 3'd4 || op == 3'd6;
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: state_next = accept ? (seq_op == 3'd7 ? DONE : LO) : IDLE;
            LO: case (op)
                3'd1, 3'd2: state_next = cin ? FIX : DONE;
                3'd3, 3'd4: state_next = HI;
                3'd5:       state_next = alu_out == 8'h00 ? FIX : DONE;
                3'd6:       state_next = alu_out == 8'hFF ? FIX : DONE;
                default:    state_next = DONE;
            endcase
            HI:  state_next = lo_f[0] ? FIX : DONE;
            FIX: state_next = DONE;
            default: state_next = IDLE;
        endcase
    end
    always_comb begin
        alu_a = 8'h00;
        alu_b = 8'h00;
        alu_opcode = ADD;
        case (state)
            LO: begin
                alu_a = a[7:0];
                alu_b = (op == 3'd5 || op == 3'd6) ? 8'h00 : b[7:0];
                alu_opcode = op == 3'd0 ? aop : op == 3'd5 ? INC : op == 3'd6 ? DEC : neg ? SUB : ADD;
            end
            HI: begin
                alu_a = a[15:8];
                alu_b = b[15:8];
                alu_opcode = neg ? SUB : ADD;
            end
            FIX: begin
                alu_a = (op == 3'd1 || op == 3'd2) ? lo : is16 ? hi : a[15:8];
                alu_opcode = neg ? DEC : INC;
            end
            default: ;
        endcase
    end
    // pf: flags of the pass that owns H/PV and the base carry for this op
    assign pf = state == FIX ? (is16 ? hi_f : lo_f) : alu_flags;
    assign fixc = state == FIX && alu_flags[0];
    always_comb begin
        res_n = result;
        flg_n = flags;
        case (op)
            3'd0: begin
                res_n = {8'h00, alu_out};
                flg_n = alu_flags;
            end
            3'd1, 3'd2: begin
                res_n = {8'h00, alu_out};
                flg_n = {alu_out[7], alu_out == 8'h00, 1'b0, pf[4], 1'b0, pf[2], neg, pf[0] | fixc};
            end
            3'd3, 3'd4: begin
                res_n = {alu_out, lo};
                flg_n = {alu_out[7], {alu_out, lo} == 16'h0000, 1'b0, pf[4], 1'b0, 1'b0, neg, pf[0] | fixc};
            end
            3'd5, 3'd6: res_n = state == FIX ? {alu_out, lo} : {a[15:8], alu_out};
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            result <= 16'h0000;
            flags <= 8'h00;
            op <= 3'd0;
            aop <= 5'd0;
            a <= 16'h0000;
            b <= 16'h0000;
            cin <= 1'b0;
            lo <= 8'h00;
            lo_f <= 8'h00;
            hi <= 8'h00;
            hi_f <= 8'h00;
        end else begin
            state <= state_next;
            if (accept) begin
                op <= seq_op;
                aop <= alu_op_in;
                a <= opnd_a;
                b <= opnd_b;
                cin <= carry_in;
            end
            if (state == LO) begin
                lo <= alu_out;
                lo_f <= alu_flags;
            end
            if (state == HI) begin
                hi <= alu_out;
                hi_f <= alu_flags;
            end
            if (busy && state_next == DONE) begin
                result <= res_n;
                flags <= flg_n;
            end
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed checks of alu_sequencer against a behavioural 8-bit ALU.
module tb_alu_sequencer;
    logic clk = 0, reset = 1, start = 0, carry_in = 0;
    logic [2:0] seq_op = 0;
    logic [4:0] alu_op_in = 0, alu_opcode;
    logic [15:0] opnd_a = 0, opnd_b = 0, result;
    logic [7:0] flags, alu_a, alu_b, alu_out, alu_flags;
    logic busy, done;
    int vecs = 0, errs = 0;

    alu_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .seq_op(seq_op), .alu_op_in(alu_op_in),
        .opnd_a(opnd_a), .opnd_b(opnd_b), .carry_in(carry_in), .busy(busy), .done(done),
        .result(result), .flags(flags), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_out(alu_out), .alu_flags(alu_flags)
    );

    always #5 clk = ~clk;

    // ALU: 0 ADD, 1 SUB, 4 XOR, 12 INC, 13 DEC; INC/DEC report wrap in C
    logic [7:0] r;
    logic h, v, n, c;
    always_comb begin
        r = 8'h00; h = 0; v = 0; n = 0; c = 0;
        case (alu_opcode)
            5'd0: begin
                {c, r} = {1'b0, alu_a} + {1'b0, alu_b};
                h = ({1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]}) > 5'd15;
                v = (alu_a[7] == alu_b[7]) && (r[7] != alu_a[7]);
            end
            5'd1: begin
                {c, r} = {1'b0, alu_a} - {1'b0, alu_b};
                h = alu_a[3:0] < alu_b[3:0];
                v = (alu_a[7] != alu_b[7]) && (r[7] != alu_a[7]);
                n = 1;
            end
            5'd4: begin
                r = alu_a ^ alu_b;
                v = ~^r;
            end
            5'd12: begin
                r = alu_a + 8'd1;
                h = alu_a[3:0] == 4'hF;
                v = alu_a == 8'h7F;
                c = alu_a == 8'hFF;
            end
            5'd13: begin
                r = alu_a - 8'd1;
                h = alu_a[3:0] == 4'h0;
                v = alu_a == 8'h80;
                c = alu_a == 8'h00;
                n = 1;
            end
            default: ;
        endcase
        alu_out = r;
        alu_flags = {r[7], r == 8'h00, 1'b0, h, 1'b0, v, n, c};
    end

    task automatic run_op(input logic [2:0] o, input logic [4:0] ao, input logic [15:0] x, input logic [15:0] y,
                          input logic ci, output int lat);
        @(negedge clk);
        seq_op = o; alu_op_in = ao; opnd_a = x; opnd_b = y; carry_in = ci; start = 1;
        @(posedge clk); #1;
        start = 0;
        lat = 1;
        while (!done && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        vecs++;
        if ({busy, done} !== 2'b00) begin errs++; $display("FAIL reset_ctl busy/done=%b want 00", {busy, done}); end
        vecs++;
        if ({result, flags} !== 24'h0) begin errs++; $display("FAIL reset_res result=%h flags=%h want 0000/00", result, flags); end
        vecs++;
        if ({alu_a, alu_b, alu_opcode} !== 21'h0) begin errs++; $display("FAIL reset_alu a=%h b=%h op=%h want 0", alu_a, alu_b, alu_opcode); end
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_add16_ripple;
        int lat;
        run_op(3'd3, 5'd0, 16'h00FF, 16'h0001, 1'b0, lat);
        vecs++;
        if (lat !== 4) begin errs++; $display("FAIL add16_ripple_lat got=%0d want=4", lat); end
        vecs++;
        if (result !== 16'h0100 || flags !== 8'h00) begin errs++; $display("FAIL add16_ripple result=%h flags=%h want 0100/00", result, flags); end
    endtask

    task automatic test_add16_wrap;
        int lat;
        run_op(3'd3, 5'd0, 16'hFFFF, 16'h0001, 1'b0, lat);
        vecs++;
        if (lat !== 4 || result !== 16'h0000 || flags !== 8'h41) begin
            errs++; $display("FAIL add16_wrap lat=%0d result=%h flags=%h want 4/0000/41", lat, result, flags);
        end
    endtask

    task automatic test_sub16_borrow;
        int lat;
        run_op(3'd4, 5'd0, 16'h0100, 16'h0001, 1'b0, lat);
        vecs++;
        if (lat !== 4 || result !== 16'h00FF || flags !== 8'h02) begin
            errs++; $display("FAIL sub16_borrow lat=%0d result=%h flags=%h want 4/00ff/02", lat, result, flags);
        end
    endtask

    task automatic test_adc8;
        int lat;
        run_op(3'd1, 5'd0, 16'h127F, 16'h3400, 1'b1, lat);
        vecs++;
        if (lat !== 3 || result !== 16'h0080 || flags !== 8'h80) begin
            errs++; $display("FAIL adc8 lat=%0d result=%h flags=%h want 3/0080/80", lat, result, flags);
        end
    endtask

    task automatic test_sbc8;
        int lat;
        run_op(3'd2, 5'd0, 16'h0000, 16'h0000, 1'b1, lat);
        vecs++;
        if (lat !== 3 || result !== 16'h00FF || flags !== 8'h83) begin
            errs++; $display("FAIL sbc8 lat=%0d result=%h flags=%h want 3/00ff/83", lat, result, flags);
        end
    endtask

    task automatic test_single;
        int lat;
        run_op(3'd0, 5'd4, 16'hAA55, 16'h00FF, 1'b0, lat);
        vecs++;
        if (lat !== 2 || result !== 16'h00AA || flags !== 8'h84) begin
            errs++; $display("FAIL single_xor lat=%0d result=%h flags=%h want 2/00aa/84", lat, result, flags);
        end
    endtask

    task automatic test_inc_dec16;
        int lat;
        run_op(3'd5, 5'd0, 16'h12FF, 16'h5555, 1'b0, lat);
        vecs++;
        if (lat !== 3 || result !== 16'h1300 || flags !== 8'h84) begin
            errs++; $display("FAIL inc16 lat=%0d result=%h flags=%h want 3/1300/84", lat, result, flags);
        end
        run_op(3'd6, 5'd0, 16'h0000, 16'h0000, 1'b0, lat);
        vecs++;
        if (lat !== 3 || result !== 16'hFFFF || flags !== 8'h84) begin
            errs++; $display("FAIL dec16 lat=%0d result=%h flags=%h want 3/ffff/84", lat, result, flags);
        end
        run_op(3'd5, 5'd0, 16'h4410, 16'h0000, 1'b0, lat);
        vecs++;
        if (lat !== 2 || result !== 16'h4411) begin
            errs++; $display("FAIL inc16_nofix lat=%0d result=%h want 2/4411", lat, result);
        end
    endtask

    task automatic test_reserved;
        int lat;
        run_op(3'd7, 5'd0, 16'h1234, 16'h5678, 1'b1, lat);
        vecs++;
        if (lat !== 1 || result !== 16'h4411 || flags !== 8'h84) begin
            errs++; $display("FAIL reserved lat=%0d result=%h flags=%h want 1/4411/84", lat, result, flags);
        end
    endtask

    task automatic test_busy_ignore;
        int lat;
        @(negedge clk);
        seq_op = 3'd3; opnd_a = 16'h00FF; opnd_b = 16'h0001; start = 1;
        @(posedge clk); #1;
        seq_op = 3'd0; alu_op_in = 5'd4; opnd_a = 16'h0F0F; opnd_b = 16'h0F0F;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 0;
        lat = 3;
        while (!done && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        vecs++;
        if (lat !== 4 || result !== 16'h0100) begin
            errs++; $display("FAIL busy_ignore lat=%0d result=%h want 4/0100", lat, result);
        end
        @(posedge clk); #1;
        vecs++;
        if ({busy, done} !== 2'b00) begin errs++; $display("FAIL busy_ignore_idle busy/done=%b want 00", {busy, done}); end
    endtask

    task automatic test_back_to_back;
        int lat;
        run_op(3'd0, 5'd4, 16'h0033, 16'h0011, 1'b0, lat);
        vecs++;
        if (done !== 1'b1 || result !== 16'h0022) begin errs++; $display("FAIL b2b_first done=%b result=%h want 1/0022", done, result); end
        @(negedge clk);
        seq_op = 3'd3; opnd_a = 16'h0101; opnd_b = 16'h0101; start = 1;
        @(posedge clk); #1;
        start = 0;
        vecs++;
        if ({busy, done} !== 2'b10 || alu_a !== 8'h01 || alu_b !== 8'h01) begin
            errs++; $display("FAIL b2b_accept busy/done=%b a=%h b=%h want 10/01/01", {busy, done}, alu_a, alu_b);
        end
        lat = 1;
        while (!done && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        vecs++;
        if (lat !== 3 || result !== 16'h0202 || flags !== 8'h00) begin
            errs++; $display("FAIL b2b_second lat=%0d result=%h flags=%h want 3/0202/00", lat, result, flags);
        end
    endtask

    task automatic test_reset_mid_op;
        int seen = 0;
        @(negedge clk);
        seq_op = 3'd3; opnd_a = 16'h00FF; opnd_b = 16'h0001; start = 1;
        @(posedge clk); #1;
        start = 0;
        @(posedge clk); #1;
        vecs++;
        if (busy !== 1'b1 || alu_a !== 8'h00) begin errs++; $display("FAIL midop_hi busy=%b alu_a=%h want 1/00", busy, alu_a); end
        @(negedge clk);
        reset = 1;
        @(posedge clk); #1;
        vecs++;
        if ({busy, done} !== 2'b00 || result !== 16'h0000 || flags !== 8'h00) begin
            errs++; $display("FAIL midop_reset busy/done=%b result=%h flags=%h want 00/0000/00", {busy, done}, result, flags);
        end
        @(negedge clk);
        reset = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        vecs++;
        if (seen !== 0) begin errs++; $display("FAIL midop_no_done pulses=%0d want 0", seen); end
    endtask

    initial begin
        test_reset;
        test_add16_ripple;
        test_add16_wrap;
        test_sub16_borrow;
        test_adc8;
        test_sbc8;
        test_single;
        test_inc_dec16;
        test_reserved;
        test_busy_ignore;
        test_back_to_back;
        test_reset_mid_op;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
